// File: rtl/apb4_rom_arbiter_pkg.sv
// ============================================================================
// Module  : apb4_rom_arbiter_pkg
// Brief   : Shared types and constants for the APB4 boot ROM/RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb4_rom_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2,
        ARB_ERR    = 2'd3
    } apb_arb_state_e;

    localparam int unsigned ApbArbReqs = 2;

endpackage

`default_nettype wire

// File: rtl/apb4_rr_grant.sv
// ============================================================================
// Module  : apb4_rr_grant
// Brief   : Two-way round-robin grant; the requester not served last wins ties.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb4_rr_grant
    import apb4_rom_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ApbArbReqs-1:0] i_req,
    input  logic                  i_advance,
    input  logic                  i_served,
    output logic [ApbArbReqs-1:0] o_gnt
);

    // Index of the requester that wins when both are asking.
    logic r_prio;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (i_advance) begin
            r_prio <= ~i_served;
        end
    end

    always_comb begin
        o_gnt = '0;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_prio ? 2'b10 : 2'b01;
            default: o_gnt = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/apb4_rom_arbiter.sv
// ============================================================================
// Module  : apb4_rom_arbiter
// Brief   : Two-requester APB4 arbiter/sequencer with local range/lock rejection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb4_rom_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_lock_i,

    input  logic                    m0_psel_i,
    input  logic                    m0_penable_i,
    input  logic                    m0_pwrite_i,
    input  logic [31:0]             m0_paddr_i,
    input  logic [DATA_WIDTH-1:0]   m0_pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] m0_pstrb_i,
    output logic                    m0_pready_o,
    output logic [DATA_WIDTH-1:0]   m0_prdata_o,
    output logic                    m0_pslverr_o,

    input  logic                    m1_psel_i,
    input  logic                    m1_penable_i,
    input  logic                    m1_pwrite_i,
    input  logic [31:0]             m1_paddr_i,
    input  logic [DATA_WIDTH-1:0]   m1_pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] m1_pstrb_i,
    output logic                    m1_pready_o,
    output logic [DATA_WIDTH-1:0]   m1_prdata_o,
    output logic                    m1_pslverr_o,

    output logic                    s_psel_o,
    output logic                    s_penable_o,
    output logic                    s_pwrite_o,
    output logic [31:0]             s_paddr_o,
    output logic [DATA_WIDTH-1:0]   s_pwdata_o,
    output logic [DATA_WIDTH/8-1:0] s_pstrb_o,
    input  logic                    s_pready_i,
    input  logic [DATA_WIDTH-1:0]   s_prdata_i,
    input  logic                    s_pslverr_i
);

    import apb4_rom_arbiter_pkg::*;

    apb_arb_state_e          r_state;
    apb_arb_state_e          w_next;

    logic                    r_gnt;
    logic                    r_write;
    logic [31:0]             r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_strb;

    logic [ApbArbReqs-1:0]   w_req;
    logic [ApbArbReqs-1:0]   w_gnt;
    logic                    w_sel;
    logic                    w_write;
    logic [31:0]             w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_reject;
    logic                    w_advance;
    logic                    w_bus_on;
    logic                    w_done;
    logic                    w_done0;
    logic                    w_done1;
    logic                    w_err;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_unused;

    assign w_req = {m1_psel_i, m0_psel_i};

    apb4_rr_grant u_rr_grant (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .i_advance (w_advance),
        .i_served  (r_gnt),
        .o_gnt     (w_gnt)
    );

    assign w_sel   = w_gnt[1];
    assign w_write = w_sel ? m1_pwrite_i : m0_pwrite_i;
    assign w_addr  = w_sel ? m1_paddr_i  : m0_paddr_i;
    assign w_wdata = w_sel ? m1_pwdata_i : m0_pwdata_i;
    assign w_strb  = w_sel ? m1_pstrb_i  : m0_pstrb_i;

    // Lock is only consulted here, so a later change cannot affect a granted transfer.
    assign w_reject = ((w_addr >> ADDR_WIDTH) != 32'd0) || (w_write && wr_lock_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if ((r_state == ARB_IDLE) && (|w_req)) begin
            r_gnt   <= w_sel;
            r_write <= w_write;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_strb  <= w_strb;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (|w_req) begin
                    w_next = w_reject ? ARB_ERR : ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                w_next = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (s_pready_i) begin
                    w_next    = ARB_IDLE;
                    w_advance = 1'b1;
                end
            end
            ARB_ERR: begin
                w_next    = ARB_IDLE;
                w_advance = 1'b1;
            end
            default: begin
                w_next = ARB_IDLE;
            end
        endcase
    end

    assign w_bus_on    = (r_state == ARB_SETUP) || (r_state == ARB_ACCESS);
    assign s_psel_o    = w_bus_on;
    assign s_penable_o = (r_state == ARB_ACCESS);
    assign s_pwrite_o  = w_bus_on && r_write;
    assign s_paddr_o   = w_bus_on ? r_addr  : '0;
    assign s_pwdata_o  = w_bus_on ? r_wdata : '0;
    assign s_pstrb_o   = w_bus_on ? r_strb  : '0;

    // Response is steered to the latched grant; the other requester sees zeros.
    assign w_done  = ((r_state == ARB_ACCESS) && s_pready_i) || (r_state == ARB_ERR);
    assign w_err   = (r_state == ARB_ERR) || s_pslverr_i;
    assign w_rdata = ((r_state == ARB_ACCESS) && !r_write) ? s_prdata_i : '0;
    assign w_done0 = w_done && !r_gnt;
    assign w_done1 = w_done &&  r_gnt;

    assign m0_pready_o  = w_done0;
    assign m0_pslverr_o = w_done0 && w_err;
    assign m0_prdata_o  = w_done0 ? w_rdata : '0;
    assign m1_pready_o  = w_done1;
    assign m1_pslverr_o = w_done1 && w_err;
    assign m1_prdata_o  = w_done1 ? w_rdata : '0;

    assign w_unused = ^{m0_penable_i, m1_penable_i, w_gnt[0]};

endmodule

`default_nettype wire

// File: tb/tb_apb4_rom_arbiter.sv
// ============================================================================
// Module  : tb_apb4_rom_arbiter
// Brief   : Self-checking bench: transaction model, memory scoreboard, directed cases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb4_rom_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_lock = 1'b0;

    logic          psel    [2];
    logic          penable [2];
    logic          pwrite  [2];
    logic [31:0]   paddr   [2];
    logic [DW-1:0] pwdata  [2];
    logic [SW-1:0] pstrb   [2];
    logic          pready  [2];
    logic [DW-1:0] prdata  [2];
    logic          pslverr [2];

    logic          s_psel, s_penable, s_pwrite;
    logic [31:0]   s_paddr;
    logic [DW-1:0] s_pwdata;
    logic [SW-1:0] s_pstrb;
    logic          s_pready = 1'b1;
    logic          s_pslverr = 1'b0;
    logic [DW-1:0] s_prdata;

    logic [DW-1:0] slave_mem [16];
    logic [DW-1:0] ref_mem   [16];

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;
    int  spsel_cnt = 0;

    always #5 clk = ~clk;

    apb4_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_lock_i    (wr_lock),
        .m0_psel_i    (psel[0]),
        .m0_penable_i (penable[0]),
        .m0_pwrite_i  (pwrite[0]),
        .m0_paddr_i   (paddr[0]),
        .m0_pwdata_i  (pwdata[0]),
        .m0_pstrb_i   (pstrb[0]),
        .m0_pready_o  (pready[0]),
        .m0_prdata_o  (prdata[0]),
        .m0_pslverr_o (pslverr[0]),
        .m1_psel_i    (psel[1]),
        .m1_penable_i (penable[1]),
        .m1_pwrite_i  (pwrite[1]),
        .m1_paddr_i   (paddr[1]),
        .m1_pwdata_i  (pwdata[1]),
        .m1_pstrb_i   (pstrb[1]),
        .m1_pready_o  (pready[1]),
        .m1_prdata_o  (prdata[1]),
        .m1_pslverr_o (pslverr[1]),
        .s_psel_o     (s_psel),
        .s_penable_o  (s_penable),
        .s_pwrite_o   (s_pwrite),
        .s_paddr_o    (s_paddr),
        .s_pwdata_o   (s_pwdata),
        .s_pstrb_o    (s_pstrb),
        .s_pready_i   (s_pready),
        .s_prdata_i   (s_prdata),
        .s_pslverr_i  (s_pslverr)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: small memory aliased on addr[5:2], writes honour strobes
    assign s_prdata = slave_mem[s_paddr[5:2]];
    always @(posedge clk) begin
        if (s_psel && s_penable && s_pready && !s_pslverr && s_pwrite) begin
            for (int b = 0; b < SW; b++) begin
                if (s_pstrb[b]) slave_mem[s_paddr[5:2]][8*b +: 8] <= s_pwdata[8*b +: 8];
            end
        end
    end

    always @(negedge clk) if (s_psel) spsel_cnt++;

    // Transaction-level model: one outstanding transfer, age counts cycles since grant
    bit          md_busy = 1'b0;
    bit          md_err, md_write;
    int          md_age, md_own;
    int          md_pref = 0;
    logic [31:0] md_addr;
    logic [DW-1:0] md_wdata;
    logic [SW-1:0] md_strb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_busy = 1'b0;
            md_pref = 0;
            md_age  = 0;
        end else if (md_busy) begin
            if (md_err) begin
                md_busy = 1'b0;
                md_pref = 1 - md_own;
            end else if (md_age == 0) begin
                md_age = 1;
            end else if (s_pready) begin
                md_busy = 1'b0;
                md_pref = 1 - md_own;
            end
        end else if (psel[0] || psel[1]) begin
            md_own   = (psel[0] && psel[1]) ? md_pref : (psel[1] ? 1 : 0);
            md_write = pwrite[md_own];
            md_addr  = paddr[md_own];
            md_wdata = pwdata[md_own];
            md_strb  = pstrb[md_own];
            md_err   = (md_addr >= 32'(2 ** AW)) || (md_write && wr_lock);
            md_busy  = 1'b1;
            md_age   = 0;
        end
    end

    always @(negedge clk) begin
        logic [101:0] eb;
        logic [33:0]  er0, er1, er;
        if (chk_en) begin
            eb = '0; er0 = '0; er1 = '0; er = '0;
            if (!rst && md_busy) begin
                if (md_err) begin
                    er = {1'b1, 1'b1, 32'h0};
                end else begin
                    eb = {1'b1, (md_age != 0), md_write, md_addr, md_wdata, md_strb};
                    if (md_age != 0 && s_pready)
                        er = {1'b1, s_pslverr, (md_write ? 32'h0 : s_prdata)};
                end
                if (md_own == 0) er0 = er; else er1 = er;
            end
            check("slave_bus", {s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb}, eb);
            check("m0_resp", {pready[0], pslverr[0], prdata[0]}, er0);
            check("m1_resp", {pready[1], pslverr[1], prdata[1]}, er1);
        end
    end

    // End-to-end scoreboard from the requesters' point of view
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int n = 0; n < 2; n++) begin
                if (pready[n] && psel[n] && !pslverr[n]) begin
                    if (pwrite[n]) begin
                        for (int b = 0; b < SW; b++)
                            if (pstrb[n][b]) ref_mem[paddr[n][5:2]][8*b +: 8] = pwdata[n][8*b +: 8];
                    end else begin
                        check("e2e_rdata", prdata[n], ref_mem[paddr[n][5:2]]);
                    end
                end
            end
        end
    end

    task automatic req(input int n, input bit w, input logic [31:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
        psel[n] = 1'b1; penable[n] = 1'b0; pwrite[n] = w;
        paddr[n] = a; pwdata[n] = d; pstrb[n] = s;
    endtask

    task automatic drop(input int n);
        psel[n] = 1'b0; penable[n] = 1'b0;
    endtask

    task automatic wait_any(output int who);
        who = -1;
        for (int k = 0; k < 50 && who < 0; k++) begin
            @(negedge clk);
            if (pready[0]) who = 0;
            else if (pready[1]) who = 1;
        end
        if (who < 0) begin
            tests++; fails++;
            $display("FAIL wait_timeout actual=none required=pready at %0t", $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r <= 10) return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        if (r == 11) return 32'h0000_1FFC;
        if (r == 12) return 32'h0000_2000;
        if (r == 13) return 32'h0000_4000;
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    initial begin
        int who, s0;
        bit done [2];
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'hA5A5_0000 | 32'(i);
            ref_mem[i]   = 32'hA5A5_0000 | 32'(i);
        end
        for (int n = 0; n < 2; n++) begin
            psel[n] = 0; penable[n] = 0; pwrite[n] = 0;
            paddr[n] = 0; pwdata[n] = 0; pstrb[n] = 0;
        end
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        check("reset_bus", {s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb}, 0);
        check("reset_resp", {pready[0], pslverr[0], prdata[0], pready[1], pslverr[1], prdata[1]}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Both request after reset: m0, then m1 while m0 re-requests, then m0
        @(posedge clk); #1 req(0, 0, 32'h0, 0, 0); req(1, 0, 32'h4, 0, 0);
        wait_any(who); check("rr_first_m0", who, 0);
        @(posedge clk); #1 req(0, 0, 32'h8, 0, 0);
        wait_any(who); check("rr_second_m1", who, 1);
        @(posedge clk); #1 drop(1);
        wait_any(who); check("rr_third_m0", who, 0);
        @(posedge clk); #1 drop(0);

        // Single read, minimum latency
        @(posedge clk); #1 req(0, 0, 32'h10, 0, 0);
        @(negedge clk); check("rd_cyc0_idle", s_psel, 0);
        @(negedge clk); check("rd_cyc1_setup", {s_psel, s_penable, s_paddr}, {1'b1, 1'b0, 32'h10});
        @(negedge clk); check("rd_cyc2_data", {pready[0], pslverr[0], prdata[0]}, {1'b1, 1'b0, 32'hA5A5_0004});
        @(posedge clk); #1 drop(0);

        // Partial-strobe write by m1, then read back by m0
        @(posedge clk); #1 req(1, 1, 32'h20, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("wr_slave_bus", {s_pwrite, s_pstrb, s_pwdata}, {1'b1, 4'b0011, 32'hDEAD_BEEF});
        check("wr_resp", {pready[1], pslverr[1]}, 2'b10);
        @(posedge clk); #1 drop(1); req(0, 0, 32'h20, 0, 0);
        wait_any(who); check("wr_readback", prdata[0], 32'hA5A5_BEEF);
        @(posedge clk); #1 drop(0);

        // Locked write rejected locally
        s0 = spsel_cnt;
        @(posedge clk); #1 wr_lock = 1'b1; req(0, 1, 32'h8, 32'h1234_5678, 4'hF);
        @(negedge clk); @(negedge clk);
        check("lock_err", {pready[0], pslverr[0], prdata[0]}, {1'b1, 1'b1, 32'h0});
        @(posedge clk); #1 drop(0); wr_lock = 1'b0;
        @(negedge clk); check("lock_no_slave", spsel_cnt - s0, 0);

        // Out-of-range read rejected locally
        s0 = spsel_cnt;
        @(posedge clk); #1 req(1, 0, 32'h0000_4000, 0, 0);
        @(negedge clk); @(negedge clk);
        check("oor_err", {pready[1], pslverr[1], prdata[1]}, {1'b1, 1'b1, 32'h0});
        @(posedge clk); #1 drop(1);
        @(negedge clk); check("oor_no_slave", spsel_cnt - s0, 0);

        // Lock raised after grant does not affect in-flight write
        @(posedge clk); #1 req(0, 1, 32'h30, 32'h1122_3344, 4'hF);
        @(posedge clk); #1 wr_lock = 1'b1;
        @(negedge clk); @(negedge clk);
        check("late_lock", {pready[0], pslverr[0]}, 2'b10);
        @(posedge clk); #1 drop(0); wr_lock = 1'b0;

        // Reset during the second wait state
        s_pready = 1'b0;
        @(posedge clk); #1 req(0, 0, 32'h0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("async_rst_bus", {s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb}, 0);
        check("async_rst_resp", {pready[0], pslverr[0], prdata[0]}, 0);
        @(posedge clk); #1 rst = 1'b0; drop(0); s_pready = 1'b1;
        @(negedge clk); check("post_rst_idle", {s_psel, pready[0]}, 0);

        // Round-robin pointer restored by reset
        @(posedge clk); #1 req(0, 0, 32'h4, 0, 0); req(1, 0, 32'h8, 0, 0);
        wait_any(who); check("rst_rr_m0", who, 0);
        @(posedge clk); #1 drop(0);
        wait_any(who); check("rst_rr_m1", who, 1);
        @(posedge clk); #1 drop(1);

        // Randomized traffic
        done[0] = 0; done[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            done[0] = pready[0]; done[1] = pready[1];
            @(posedge clk); #1;
            s_pready  = ($urandom_range(0, 2) != 0);
            s_pslverr = ($urandom_range(0, 7) == 0);
            wr_lock   = ($urandom_range(0, 5) == 0);
            for (int n = 0; n < 2; n++) begin
                if (psel[n] && done[n]) drop(n);
                else if (psel[n]) penable[n] = 1'b1;
                if (!psel[n] && $urandom_range(0, 2) == 0)
                    req(n, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            end
        end
        s_pready = 1'b1; s_pslverr = 1'b0; wr_lock = 1'b0;
        for (int k = 0; k < 20 && (psel[0] || psel[1]); k++) begin
            @(negedge clk);
            done[0] = pready[0]; done[1] = pready[1];
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) if (psel[n] && done[n]) drop(n);
        end
        check("drain", {psel[0], psel[1]}, 0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 16; i++) check("mem_final", slave_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
